// File: rtl/serial_incrementer_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial incrementer.
interface serial_incrementer_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y;
  logic             Cout;

  modport master (output start, A, input busy, done, Y, Cout);
  modport slave  (input start, A, output busy, done, Y, Cout);
endinterface

// File: rtl/serial_incrementer.sv
// Bit-serial A+1: one bit-slice per clock, LSB first, ripple carry seeded at 1.
// Optional macro SERIAL_INC_EARLY_EXIT_EN: finish as soon as the carry dies out.
module serial_incrementer #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_incrementer_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] y_q, y_nxt;
  logic             cout_q, cout_nxt;
  logic             carry_q, carry_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             busy_q, done_q;
  logic             bit_carry;
  logic             last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      y_q     <= y_nxt;
      cout_q  <= cout_nxt;
      carry_q <= carry_nxt;
      idx     <= idx_nxt;
      // Handshake outputs are flops decoded from the next state, not from state.
      busy_q  <= (state_nxt == RUN);
      done_q  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    y_nxt     = y_q;
    cout_nxt  = cout_q;
    carry_nxt = carry_q;
    idx_nxt   = idx;
    bit_carry = a_q[idx] & carry_q;
    last      = (idx == IW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          a_nxt     = bus.A;
          carry_nxt = 1'b1;
          idx_nxt   = '0;
          y_nxt     = '0;
          cout_nxt  = 1'b0;
        end
      end
      RUN: begin
        y_nxt[idx] = a_q[idx] ^ carry_q;
        carry_nxt  = bit_carry;
        idx_nxt    = idx + 1'b1;
        if (last) begin
          state_nxt = DONE;
          cout_nxt  = bit_carry;
          idx_nxt   = '0;
        end
`ifdef SERIAL_INC_EARLY_EXIT_EN
        else if (!bit_carry) begin
          // Carry is dead: the remaining upper bits pass through unchanged.
          for (int j = 0; j < WIDTH; j++)
            if (j > int'(idx)) y_nxt[j] = a_q[j];
          state_nxt = DONE;
          cout_nxt  = 1'b0;
          idx_nxt   = '0;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Y    = y_q;
  assign bus.Cout = cout_q;
endmodule
